// File: rtl/base_cntr_dump.sv
// base_cntr_dump: sweeps counters 0..n-1 through a valid/ready read port and
// returns each (address, value) pair as a dump record on a second
// valid/ready port. Up to max_out read requests may be outstanding at the
// counter block. Read data is assumed to come back in request order.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   i_start_v / i_start_r    dump request handshake (ready only when idle)
//   o_rd_v / o_rd_r / o_rd_a read request to the counter block
//   i_rd_v / i_rd_r / i_rd_d read data from the counter block
//   o_v / o_r / o_a / o_d    dump record (address, value)
//   o_last                   record carries address n-1
//   o_busy                   dump in progress
module base_cntr_dump #(
  parameter int width      = 32,
  parameter int n          = 2,
  parameter int addr_width = (n > 1) ? $clog2(n) : 1,
  parameter int max_out    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start_v,
  output logic                  i_start_r,
  output logic                  o_rd_v,
  input  logic                  o_rd_r,
  output logic [addr_width-1:0] o_rd_a,
  input  logic                  i_rd_v,
  output logic                  i_rd_r,
  input  logic [width-1:0]      i_rd_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [addr_width-1:0] o_a,
  output logic [width-1:0]      o_d,
  output logic                  o_last,
  output logic                  o_busy
);
  localparam int OW = $clog2(max_out + 1);
  localparam logic [addr_width-1:0] LAST_A = addr_width'(n - 1);
  localparam logic [OW-1:0]         MAX_O  = OW'(max_out);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] iss_a_q, iss_a_d;
  logic [addr_width-1:0] rsp_a_q, rsp_a_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  v_q, v_d;
  logic [addr_width-1:0] a_q, a_d;
  logic [width-1:0]      d_q, d_d;
  logic                  last_q, last_d;

  logic start_x, rd_x, rsp_x, out_x, load, dec;

  assign i_start_r = (state_q == IDLE);
  assign o_busy    = (state_q != IDLE);
  assign o_rd_v    = (state_q == ISSUE) && (out_q < MAX_O);
  assign o_rd_a    = iss_a_q;
  // One-entry output register: accept data whenever it is empty or draining.
  assign i_rd_r    = ~v_q | o_r;
  assign o_v       = v_q;
  assign o_a       = a_q;
  assign o_d       = d_q;
  assign o_last    = last_q;

  assign start_x = i_start_v & i_start_r;
  assign rd_x    = o_rd_v & o_rd_r;
  assign rsp_x   = i_rd_v & i_rd_r;
  assign out_x   = v_q & o_r;
  // Responses seen while idle (e.g. left over from an abandoned dump) are
  // swallowed without producing a record.
  assign load    = rsp_x & o_busy;
  // Never underflow: stale responses after a reset must not wrap the count.
  assign dec     = rsp_x & (out_q != '0);

  always_comb begin
    state_d = state_q;
    iss_a_d = iss_a_q;
    rsp_a_d = rsp_a_q;
    out_d   = out_q;
    v_d     = v_q;
    a_d     = a_q;
    d_d     = d_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (start_x) begin
          state_d = ISSUE;
          iss_a_d = '0;
          rsp_a_d = '0;
        end
      end
      ISSUE: begin
        if (rd_x) begin
          iss_a_d = iss_a_q + addr_width'(1);
          if (iss_a_q == LAST_A) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_x && last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case ({rd_x, dec})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    if (load) begin
      v_d     = 1'b1;
      a_d     = rsp_a_q;
      d_d     = i_rd_d;
      last_d  = (rsp_a_q == LAST_A);
      rsp_a_d = rsp_a_q + addr_width'(1);
    end else if (out_x) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iss_a_q <= '0;
      rsp_a_q <= '0;
      out_q   <= '0;
      v_q     <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_a_q <= iss_a_d;
      rsp_a_q <= rsp_a_d;
      out_q   <= out_d;
      v_q     <= v_d;
      a_q     <= a_d;
      d_q     <= d_d;
      last_q  <= last_d;
    end
  end
endmodule
